// File: rtl/tdp_sram_param_pkg.sv
// Shared encodings for the true-dual-port SRAM: read-during-write modes and clear FSM states.
package tdp_sram_param_pkg;

    localparam int READ_FIRST  = 0;
    localparam int WRITE_FIRST = 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;

endpackage

// File: rtl/tdp_sram_outpipe.sv
// Per-port read return path: capture stage plus optional second register; rdata holds when idle.
module tdp_sram_outpipe #(
    parameter int WIDTH   = 18,
    parameter int OUT_REG = 0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_vld,
    input  logic [WIDTH-1:0] i_dat,
    output logic             o_vld,
    output logic [WIDTH-1:0] o_dat
);

    logic             r_vld1;
    logic [WIDTH-1:0] r_dat1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_vld1 <= 1'b0;
            r_dat1 <= '0;
        end else begin
            r_vld1 <= i_vld;
            if (i_vld) r_dat1 <= i_dat;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic             r_vld2;
            logic [WIDTH-1:0] r_dat2;

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_vld2 <= 1'b0;
                    r_dat2 <= '0;
                end else begin
                    r_vld2 <= r_vld1;
                    if (r_vld1) r_dat2 <= r_dat1;
                end
            end

            assign o_vld = r_vld2;
            assign o_dat = r_dat2;
        end else begin : g_noreg
            assign o_vld = r_vld1;
            assign o_dat = r_dat1;
        end
    endgenerate

endmodule

// File: rtl/tdp_sram_param.sv
// True-dual-port single-clock SRAM with bit masks, selectable read-during-write and optional clear after reset.
// Port A wins on bits both ports write to the same word; collision flags that case one cycle later.
module tdp_sram_param
    import tdp_sram_param_pkg::*;
#(
    parameter int WIDTH          = 18,
    parameter int DEPTH          = 1024,
    parameter int OUT_REG        = 0,
    parameter int RDW_MODE       = READ_FIRST,
    parameter int CLEAR_ON_RESET = 0,
    parameter logic [DEPTH*WIDTH-1:0] INIT = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cen_a,
    input  logic                     wen_a,
    input  logic [$clog2(DEPTH)-1:0] addr_a,
    input  logic [WIDTH-1:0]         wmsk_a,
    input  logic [WIDTH-1:0]         wdata_a,
    output logic [WIDTH-1:0]         rdata_a,
    output logic                     rvalid_a,
    input  logic                     cen_b,
    input  logic                     wen_b,
    input  logic [$clog2(DEPTH)-1:0] addr_b,
    input  logic [WIDTH-1:0]         wmsk_b,
    input  logic [WIDTH-1:0]         wdata_b,
    output logic [WIDTH-1:0]         rdata_b,
    output logic                     rvalid_b,
    output logic                     collision,
    output logic                     busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    // Packed so word i lines up with INIT[WIDTH*i +: WIDTH] directly.
    logic [DEPTH-1:0][WIDTH-1:0] r_mem = INIT;

    clr_state_t       r_state;
    clr_state_t       w_state_nxt;
    logic [AW-1:0]    r_clr_addr;
    logic             r_collision;

    logic             w_busy;
    logic             w_clr_we;
    logic             w_acc_a, w_acc_b;
    logic             w_wr_a, w_wr_b;
    logic             w_same;
    logic [WIDTH-1:0] w_bm_a, w_bm_b;
    logic [WIDTH-1:0] w_old_a, w_old_b;
    logic [WIDTH-1:0] w_self_a, w_self_b;
    logic [WIDTH-1:0] w_base_a;
    logic [WIDTH-1:0] w_new_a;
    logic [WIDTH-1:0] w_rd_a, w_rd_b;

    assign w_busy   = (r_state == ST_CLEAR);
    assign w_clr_we = w_busy & ~rst;
    assign w_acc_a  = ~cen_a & ~w_busy & ~rst;
    assign w_acc_b  = ~cen_b & ~w_busy & ~rst;
    assign w_wr_a   = w_acc_a & ~wen_a;
    assign w_wr_b   = w_acc_b & ~wen_b;
    assign w_same   = (addr_a == addr_b);
    assign w_bm_a   = w_wr_a ? ~wmsk_a : '0;
    assign w_bm_b   = w_wr_b ? ~wmsk_b : '0;
    assign w_old_a  = r_mem[addr_a];
    assign w_old_b  = r_mem[addr_b];

    assign w_self_a = (w_old_a & ~w_bm_a) | (wdata_a & w_bm_a);
    assign w_self_b = (w_old_b & ~w_bm_b) | (wdata_b & w_bm_b);

    // On a shared address port A merges over port B's result, so A takes the overlapping bits.
    assign w_base_a = (w_same && w_wr_b) ? w_self_b : w_old_a;
    assign w_new_a  = (w_base_a & ~w_bm_a) | (wdata_a & w_bm_a);

    assign w_rd_a = (RDW_MODE == WRITE_FIRST && w_wr_a) ? w_self_a : w_old_a;
    assign w_rd_b = (RDW_MODE == WRITE_FIRST && w_wr_b) ? w_self_b : w_old_b;

    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[r_clr_addr] <= '0;
        end else begin
            if (w_wr_b) r_mem[addr_b] <= w_self_b;
            if (w_wr_a) r_mem[addr_a] <= w_new_a;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  w_state_nxt = ST_IDLE;
            ST_CLEAR: if (r_clr_addr == LAST_ADDR) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clr_addr  <= '0;
            r_collision <= 1'b0;
        end else begin
            if (w_busy && r_clr_addr != LAST_ADDR) r_clr_addr <= r_clr_addr + AW'(1);
            r_collision <= w_wr_a & w_wr_b & w_same;
        end
    end

    tdp_sram_outpipe #(.WIDTH(WIDTH), .OUT_REG(OUT_REG)) u_pipe_a (
        .i_clk (clk),
        .i_rst (rst),
        .i_vld (w_acc_a),
        .i_dat (w_rd_a),
        .o_vld (rvalid_a),
        .o_dat (rdata_a)
    );

    tdp_sram_outpipe #(.WIDTH(WIDTH), .OUT_REG(OUT_REG)) u_pipe_b (
        .i_clk (clk),
        .i_rst (rst),
        .i_vld (w_acc_b),
        .i_dat (w_rd_b),
        .o_vld (rvalid_b),
        .o_dat (rdata_b)
    );

    assign collision = r_collision;
    assign busy      = w_busy;

endmodule

// File: tb/tb_tdp_sram_param.sv
// Directed checks of tdp_sram_param across default, write-first, clear-on-reset and output-register builds.
module tb_tdp_sram_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Default build (DEPTH 1024, read-first)
    logic        rst_d;
    logic        d_cen_a, d_wen_a, d_cen_b, d_wen_b;
    logic [9:0]  d_addr_a, d_addr_b;
    logic [17:0] d_wmsk_a, d_wdata_a, d_wmsk_b, d_wdata_b;
    logic [17:0] d_rdata_a, d_rdata_b;
    logic        d_rvalid_a, d_rvalid_b, d_collision, d_busy;

    tdp_sram_param u_d (
        .clk(clk), .rst(rst_d),
        .cen_a(d_cen_a), .wen_a(d_wen_a), .addr_a(d_addr_a), .wmsk_a(d_wmsk_a), .wdata_a(d_wdata_a),
        .rdata_a(d_rdata_a), .rvalid_a(d_rvalid_a),
        .cen_b(d_cen_b), .wen_b(d_wen_b), .addr_b(d_addr_b), .wmsk_b(d_wmsk_b), .wdata_b(d_wdata_b),
        .rdata_b(d_rdata_b), .rvalid_b(d_rvalid_b),
        .collision(d_collision), .busy(d_busy)
    );

    // Shared stimulus for the three DEPTH-16 builds, each with its own reset
    logic        rst_w, rst_c, rst_o;
    logic        s_cen_a, s_wen_a, s_cen_b, s_wen_b;
    logic [3:0]  s_addr_a, s_addr_b;
    logic [17:0] s_wmsk_a, s_wdata_a, s_wmsk_b, s_wdata_b;
    logic [17:0] w_rdata_a, w_rdata_b, c_rdata_a, c_rdata_b, o_rdata_a, o_rdata_b;
    logic        w_rvalid_a, w_rvalid_b, w_collision, w_busy;
    logic        c_rvalid_a, c_rvalid_b, c_collision, c_busy;
    logic        o_rvalid_a, o_rvalid_b, o_collision, o_busy;

    tdp_sram_param #(.DEPTH(16), .RDW_MODE(1)) u_w (
        .clk(clk), .rst(rst_w),
        .cen_a(s_cen_a), .wen_a(s_wen_a), .addr_a(s_addr_a), .wmsk_a(s_wmsk_a), .wdata_a(s_wdata_a),
        .rdata_a(w_rdata_a), .rvalid_a(w_rvalid_a),
        .cen_b(s_cen_b), .wen_b(s_wen_b), .addr_b(s_addr_b), .wmsk_b(s_wmsk_b), .wdata_b(s_wdata_b),
        .rdata_b(w_rdata_b), .rvalid_b(w_rvalid_b),
        .collision(w_collision), .busy(w_busy)
    );

    tdp_sram_param #(.DEPTH(16), .CLEAR_ON_RESET(1), .INIT({16{18'h15A5A}})) u_c (
        .clk(clk), .rst(rst_c),
        .cen_a(s_cen_a), .wen_a(s_wen_a), .addr_a(s_addr_a), .wmsk_a(s_wmsk_a), .wdata_a(s_wdata_a),
        .rdata_a(c_rdata_a), .rvalid_a(c_rvalid_a),
        .cen_b(s_cen_b), .wen_b(s_wen_b), .addr_b(s_addr_b), .wmsk_b(s_wmsk_b), .wdata_b(s_wdata_b),
        .rdata_b(c_rdata_b), .rvalid_b(c_rvalid_b),
        .collision(c_collision), .busy(c_busy)
    );

    tdp_sram_param #(.DEPTH(16), .OUT_REG(1)) u_o (
        .clk(clk), .rst(rst_o),
        .cen_a(s_cen_a), .wen_a(s_wen_a), .addr_a(s_addr_a), .wmsk_a(s_wmsk_a), .wdata_a(s_wdata_a),
        .rdata_a(o_rdata_a), .rvalid_a(o_rvalid_a),
        .cen_b(s_cen_b), .wen_b(s_wen_b), .addr_b(s_addr_b), .wmsk_b(s_wmsk_b), .wdata_b(s_wdata_b),
        .rdata_b(o_rdata_b), .rvalid_b(o_rvalid_b),
        .collision(o_collision), .busy(o_busy)
    );

    task automatic d_idle();
        d_cen_a = 1'b1; d_wen_a = 1'b1; d_addr_a = '0; d_wmsk_a = '1; d_wdata_a = '0;
        d_cen_b = 1'b1; d_wen_b = 1'b1; d_addr_b = '0; d_wmsk_b = '1; d_wdata_b = '0;
    endtask

    task automatic d_a(input logic wr, input logic [9:0] ad, input logic [17:0] dat, input logic [17:0] msk);
        d_cen_a = 1'b0; d_wen_a = ~wr; d_addr_a = ad; d_wdata_a = dat; d_wmsk_a = msk;
    endtask

    task automatic d_b(input logic wr, input logic [9:0] ad, input logic [17:0] dat, input logic [17:0] msk);
        d_cen_b = 1'b0; d_wen_b = ~wr; d_addr_b = ad; d_wdata_b = dat; d_wmsk_b = msk;
    endtask

    task automatic s_idle();
        s_cen_a = 1'b1; s_wen_a = 1'b1; s_addr_a = '0; s_wmsk_a = '1; s_wdata_a = '0;
        s_cen_b = 1'b1; s_wen_b = 1'b1; s_addr_b = '0; s_wmsk_b = '1; s_wdata_b = '0;
    endtask

    task automatic s_a(input logic wr, input logic [3:0] ad, input logic [17:0] dat, input logic [17:0] msk);
        s_cen_a = 1'b0; s_wen_a = ~wr; s_addr_a = ad; s_wdata_a = dat; s_wmsk_a = msk;
    endtask

    task automatic s_b(input logic wr, input logic [3:0] ad, input logic [17:0] dat, input logic [17:0] msk);
        s_cen_b = 1'b0; s_wen_b = ~wr; s_addr_b = ad; s_wdata_b = dat; s_wmsk_b = msk;
    endtask

    initial begin
        int  n;
        logic seen;

        rst_d = 1'b1; rst_w = 1'b1; rst_c = 1'b1; rst_o = 1'b1;
        d_idle();
        s_idle();
        repeat (2) tick();

        chk("rst_rdata_a", 32'(d_rdata_a), 32'h0);
        chk("rst_rvalid_a", 32'(d_rvalid_a), 32'h0);
        chk("rst_collision", 32'(d_collision), 32'h0);
        chk("rst_busy_noclear", 32'(d_busy), 32'h0);
        chk("rst_busy_clear", 32'(c_busy), 32'h1);

        rst_d = 1'b0; rst_w = 1'b0;
        tick();

        // Basic write then read, read-first on the write itself
        d_a(1'b1, 10'd5, 18'h2AAAA, 18'h0);
        tick();
        chk("wr5_rdf_rvalid", 32'(d_rvalid_a), 32'h1);
        chk("wr5_rdf_old", 32'(d_rdata_a), 32'h0);
        d_a(1'b0, 10'd5, 18'h0, 18'h3FFFF);
        tick();
        chk("rd5_rvalid", 32'(d_rvalid_a), 32'h1);
        chk("rd5_data", 32'(d_rdata_a), 32'h2AAAA);
        d_idle();
        tick();
        chk("idle_rvalid", 32'(d_rvalid_a), 32'h0);
        chk("idle_hold", 32'(d_rdata_a), 32'h2AAAA);

        // Bit mask
        d_a(1'b1, 10'd7, 18'h3FFFF, 18'h0);
        tick();
        d_a(1'b1, 10'd7, 18'h00000, 18'h3FF00);
        tick();
        chk("msk_rdf_old", 32'(d_rdata_a), 32'h3FFFF);
        d_a(1'b0, 10'd7, 18'h0, 18'h3FFFF);
        tick();
        chk("msk_data", 32'(d_rdata_a), 32'h3FF00);

        // Full collision: A wins, pulse lasts one cycle
        d_a(1'b1, 10'd9, 18'h11111, 18'h0);
        d_b(1'b1, 10'd9, 18'h22222, 18'h0);
        tick();
        chk("coll_pulse", 32'(d_collision), 32'h1);
        d_idle();
        tick();
        chk("coll_drop", 32'(d_collision), 32'h0);
        d_a(1'b0, 10'd9, 18'h0, 18'h3FFFF);
        d_b(1'b0, 10'd9, 18'h0, 18'h3FFFF);
        tick();
        chk("coll_word_a", 32'(d_rdata_a), 32'h11111);
        chk("coll_word_b", 32'(d_rdata_b), 32'h11111);
        chk("dual_rd_nocoll", 32'(d_collision), 32'h0);

        // Disjoint masks on a shared address merge both ports
        d_a(1'b1, 10'd10, 18'h3FFFF, 18'h0FFFF);
        d_b(1'b1, 10'd10, 18'h3FFFF, 18'h3FF00);
        tick();
        d_idle();
        d_a(1'b0, 10'd10, 18'h0, 18'h3FFFF);
        tick();
        chk("coll_merge", 32'(d_rdata_a), 32'h300FF);

        // Overlapping masks: A owns bits 7:4, B alone supplies 11:8
        d_a(1'b1, 10'd11, 18'h000AA, 18'h3FF00);
        d_b(1'b1, 10'd11, 18'h00555, 18'h3F00F);
        tick();
        d_idle();
        d_a(1'b0, 10'd11, 18'h0, 18'h3FFFF);
        tick();
        chk("coll_overlap", 32'(d_rdata_a), 32'h005AA);
        d_idle();

        // Write-first build: own port sees new word, other port sees old
        s_a(1'b1, 4'd3, 18'h00001, 18'h0);
        tick();
        s_a(1'b1, 4'd3, 18'h00002, 18'h0);
        s_b(1'b0, 4'd3, 18'h0, 18'h3FFFF);
        tick();
        chk("wf_own_new", 32'(w_rdata_a), 32'h00002);
        chk("wf_cross_old", 32'(w_rdata_b), 32'h00001);
        s_idle();
        s_a(1'b1, 4'd3, 18'h000F0, 18'h3FF0F);
        tick();
        chk("wf_merge", 32'(w_rdata_a), 32'h000F2);
        s_idle();
        tick();

        // Output-register build: two-cycle latency
        rst_o = 1'b0;
        tick();
        s_a(1'b1, 4'd1, 18'h12345, 18'h0);
        tick();
        s_a(1'b0, 4'd1, 18'h0, 18'h3FFFF);
        tick();
        s_idle();
        chk("oreg_wr_ret_old", 32'(o_rdata_a), 32'h0);
        tick();
        chk("oreg_rd_vld", 32'(o_rvalid_a), 32'h1);
        chk("oreg_rd_data", 32'(o_rdata_a), 32'h12345);
        tick();
        chk("oreg_vld_drop", 32'(o_rvalid_a), 32'h0);

        // Reset one cycle after an accepted read discards it
        s_a(1'b0, 4'd1, 18'h0, 18'h3FFFF);
        tick();
        s_idle();
        rst_o = 1'b1;
        #1;
        chk("oreg_rst_data", 32'(o_rdata_a), 32'h0);
        tick();
        rst_o = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            seen |= o_rvalid_a;
        end
        chk("oreg_rst_novld", 32'(seen), 32'h0);
        chk("oreg_rst_hold0", 32'(o_rdata_a), 32'h0);

        // Clear-on-reset: busy for exactly DEPTH cycles, accesses ignored
        rst_c = 1'b0;
        s_a(1'b1, 4'd0, 18'h3FFFF, 18'h0);
        n = 0;
        seen = 1'b0;
        while (c_busy && n < 100) begin
            tick();
            n++;
            seen |= c_rvalid_a;
        end
        s_idle();
        chk("clr_cycles", 32'(n), 32'd16);
        chk("clr_no_rvalid", 32'(seen), 32'h0);
        for (int i = 0; i < 16; i++) begin
            s_a(1'b0, 4'(i), 18'h0, 18'h3FFFF);
            tick();
            chk($sformatf("clr_word%0d", i), 32'(c_rdata_a), 32'h0);
            if (i == 0) chk("clr_rd_vld", 32'(c_rvalid_a), 32'h1);
        end
        s_idle();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
